// File: rtl/accumulate_scheduler.sv
// Round-robin scheduler sharing one N-bit accumulator among R requesters.
// Each job sums an arithmetic series (base, step, count) modulo 2^N and
// returns the sum with a one-cycle done pulse to the owning requester.
module accumulate_scheduler #(
  parameter int unsigned N = 8,
  parameter int unsigned R = 4,
  parameter int unsigned L = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] base,
  input  logic [R*N-1:0] step,
  input  logic [R*L-1:0] count,
  output logic [R-1:0]   gnt,
  output logic [R-1:0]   done,
  output logic [N-1:0]   result,
  output logic           busy
);

  localparam int unsigned ID_W = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nx;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] id;
  logic [ID_W-1:0] win_id;
  logic            win_valid;
  logic [ID_W:0]   cand;
  logic [N-1:0]    win_base;
  logic [N-1:0]    win_step;
  logic [L-1:0]    win_count;
  logic [N-1:0]    acc;
  logic [N-1:0]    operand;
  logic [N-1:0]    step_r;
  logic [L-1:0]    remaining;
  logic            load;
  logic            last_add;

  // Round-robin search: first requester at or after ptr, wrapping at R
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned k = 0; k < R; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(R)) begin
        cand = cand - (ID_W+1)'(R);
      end
      if (!win_valid && req[cand[ID_W-1:0]]) begin
        win_valid = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
  end

  // Job fields of the current round-robin winner
  always_comb begin
    win_base  = base[int'(win_id)*N +: N];
    win_step  = step[int'(win_id)*N +: N];
    win_count = count[int'(win_id)*L +: L];
  end

  // Next-state, grant and datapath control
  always_comb begin
    state_nx = state;
    gnt      = '0;
    load     = 1'b0;
    last_add = 1'b0;
    unique case (state)
      IDLE: begin
        if (win_valid) begin
          gnt[win_id] = 1'b1;
          load        = 1'b1;
          state_nx    = (win_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (remaining == L'(1)) begin
          last_add = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Accumulator datapath, completion pulse, result and round-robin pointer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      id        <= '0;
      acc       <= '0;
      operand   <= '0;
      step_r    <= '0;
      remaining <= '0;
      done      <= '0;
      result    <= '0;
      busy      <= 1'b0;
    end else begin
      done <= '0;
      busy <= (state_nx != IDLE);
      if (load) begin
        id        <= win_id;
        operand   <= win_base;
        step_r    <= win_step;
        remaining <= win_count;
        acc       <= '0;
        if (win_count == '0) begin
          done   <= R'(1) << win_id;
          result <= '0;
        end
      end
      if (state == RUN) begin
        acc       <= acc + operand;
        operand   <= operand + step_r;
        remaining <= remaining - L'(1);
        // The final sum includes this cycle's add, so publish it directly
        if (last_add) begin
          done   <= R'(1) << id;
          result <= acc + operand;
        end
      end
      if (state == DONE) begin
        ptr <= (id == ID_W'(R-1)) ? '0 : id + ID_W'(1);
      end
    end
  end

endmodule

// File: doc/accumulate_scheduler.md
# accumulate_scheduler

Round-robin scheduler that shares one N-bit accumulator datapath among R requesters. Each requester submits an arithmetic-series job (base, step, count). The scheduler grants one job at a time, then clears and sequences the accumulator through `count` add cycles. It returns the sum with a one-cycle completion pulse to the owning requester. It sits between client blocks and the accumulator, owning the accumulator's add/clear/operand control.

## Interface

Parameters:

- N, 8, data/accumulator width
- R, 4, number of requesters (≥2)
- L, 8, job count width

Ports:

- clock  in  1  clock; all state changes on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- req  in  R  per-requester job request; held until granted
- base  in  R*N  per-requester first operand; slice i = base[i*N +: N]
- step  in  R*N  per-requester operand increment; slice i = step[i*N +: N]
- count  in  R*L  per-requester number of operands; slice i = count[i*L +: L]
- gnt  out  R  one-hot grant, combinational, high only in the acceptance cycle
- done  out  R  one-hot registered completion pulse, 1 cycle
- result  out  N  registered job sum; valid while done is high, held until next done
- busy  out  1  registered; high when state ≠ IDLE

## Operation

- Job result = Σ_{k=0}^{count-1} (base + k·step) mod 2^N.
- Operand and accumulator registers are N bits and wrap silently; there is no overflow flag.
- FSM states: IDLE, RUN, DONE.
- IDLE, no req: stay in IDLE, all outputs quiet.
- IDLE, any req: select winner i by round-robin search starting at pointer `ptr`. Assert gnt[i] this cycle. At the edge:
  - latch id=i, operand=base_i, step_i, remaining=count_i;
  - acc ← 0;
  - go to RUN if count_i ≠ 0, else DONE.
- RUN, every cycle:
  - acc ← acc + operand; operand ← operand + step; remaining ← remaining − 1;
  - when remaining == 1 (the last add), go to DONE.
- DONE: done[id]=1 and result=acc (registered, visible this cycle). ptr ← (id+1) mod R. Go to IDLE.
- Arbitration and inputs:
  - req and inputs of non-granted requesters are ignored.
  - Inputs are sampled only in the gnt cycle; later changes do not affect the job.
  - A requester that keeps req high after gnt is treated as a new request. It competes again in the next IDLE cycle.
- Reset values: state=IDLE, ptr=0, acc=0, result=0, done=0, busy=0, gnt=0.
- Reset mid-job: the in-flight job is dropped with no done pulse. Arbitration restarts from ptr=0.

## Timing

- Let the gnt cycle be T. RUN occupies T+1..T+count. done and the result are high/valid in cycle T+count+1.
- count=0: done in T+1 with result=0.
- busy is high from T+1 through the DONE cycle inclusive.
- The earliest next gnt is cycle T+count+2, the first IDLE cycle. Per-job occupancy is count+2 cycles.
- gnt never asserts outside IDLE. At most one gnt bit and one done bit are high in any cycle.
- Fairness: each continuously requesting requester is granted within R jobs.

## Test plan

- Single job: requester 0, base=1, step=2, count=8 -> gnt[0] at T, done[0] at T+9, result=64. busy high T+1..T+9.
- Zero count: requester 2, base=5, step=3, count=0 -> done[2] at T+1, result=0, no RUN cycles.
- Wrap: N=8, base=200, step=0, count=2 -> result=144 (400 mod 256). Base=255, step=1, count=3 -> result=255+0+1 = 0.
- Round-robin: all 4 req held high with count=1 and base=i+1 -> grant order 0,1,2,3,0. Results are 1,2,3,4,1, each done one-hot to the correct id.
- Input stability: change base_1 in the cycle after gnt[1] -> result still uses the value latched at gnt.
- Reset mid-job: assert reset_n=0 during RUN of a count=8 job -> immediately busy=0, result=0, no done. After release, all req high -> first gnt goes to requester 0.
